// File: rtl/awg_pkg.sv
// awg_pkg
//   Shared definitions for the AWG segment sequencer: command opcodes,
//   payload length, generator field widths, FSM state encodings and the
//   segment table entry layout.
package awg_pkg;

  // Header byte opcodes (upper nibble)
  localparam logic [3:0] OP_CLR   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_START = 4'h2;
  localparam logic [3:0] OP_STOP  = 4'h3;

  // Number of payload bytes following a WRITE header
  localparam int PAY_BYTES = 9;

  // Generator field widths
  localparam int TYPE_W = 2;
  localparam int FREQ_W = 16;
  localparam int AMP_W  = 10;
  localparam int OFF_W  = 10;
  localparam int DUR_MAX_W = 16;

  typedef enum logic {
    P_HDR,
    P_PAY
  } parse_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } play_state_t;

  // One segment table entry. The duration is kept at full byte-pair width;
  // the parser has already masked it down to the configured DUR_W.
  typedef struct packed {
    logic [TYPE_W-1:0]    wtype;
    logic [FREQ_W-1:0]    freq;
    logic [AMP_W-1:0]     amp;
    logic [OFF_W-1:0]     off;
    logic [DUR_MAX_W-1:0] dur;
  } seg_entry_t;

endpackage

// File: rtl/awg_cmd_parser.sv
// awg_cmd_parser
//   Turns the UART byte stream into one-cycle command strobes for the
//   sequencer. A header byte {opcode, arg} either acts immediately (CLR,
//   START, STOP) or opens a 9-byte WRITE payload. All outputs are registered
//   and valid for exactly one cycle, the cycle after the byte that caused them.
// Ports
//   clk, rst_n            clock, async active-low reset
//   cfg_data, cfg_valid   received byte and its strobe
//   wr_en/wr_idx/wr_entry table write (cycle after the 9th payload byte)
//   start/last_idx        START with in-range loop end index
//   stop, clr, err_set    STOP, error clear and error set strobes
module awg_cmd_parser
  import awg_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int DUR_W   = 16,
  parameter int IDX_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output seg_entry_t       wr_entry,
  output logic             start,
  output logic [IDX_W-1:0] last_idx,
  output logic             stop,
  output logic             clr,
  output logic             err_set
);

  // Only the low DUR_W bits of the received duration are meaningful
  localparam logic [DUR_MAX_W-1:0] DUR_MASK =
    DUR_MAX_W'((32'd1 << DUR_W) - 32'd1);

  parse_state_t      state_reg;
  logic [3:0]        cnt_reg;
  logic              discard_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [TYPE_W-1:0] type_reg;
  logic [FREQ_W-1:0] freq_reg;
  logic [AMP_W-1:0]  amp_reg;
  logic [OFF_W-1:0]  off_reg;
  logic [7:0]        dur_hi_reg;

  logic [3:0] op;
  logic [3:0] arg;
  logic       arg_ok;

  assign op     = cfg_data[7:4];
  assign arg    = cfg_data[3:0];
  assign arg_ok = ({1'b0, arg} < 5'(NUM_SEG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= P_HDR;
      cnt_reg     <= '0;
      discard_reg <= 1'b0;
      idx_reg     <= '0;
      type_reg    <= '0;
      freq_reg    <= '0;
      amp_reg     <= '0;
      off_reg     <= '0;
      dur_hi_reg  <= '0;
      wr_en       <= 1'b0;
      wr_idx      <= '0;
      wr_entry    <= '0;
      start       <= 1'b0;
      last_idx    <= '0;
      stop        <= 1'b0;
      clr         <= 1'b0;
      err_set     <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      start   <= 1'b0;
      stop    <= 1'b0;
      clr     <= 1'b0;
      err_set <= 1'b0;
      if (cfg_valid) begin
        case (state_reg)
          P_HDR: begin
            case (op)
              OP_CLR: clr <= 1'b1;
              OP_WRITE: begin
                // An out-of-range index still consumes its payload so the
                // stream stays framed; the write is simply suppressed.
                state_reg   <= P_PAY;
                cnt_reg     <= '0;
                discard_reg <= !arg_ok;
                idx_reg     <= arg[IDX_W-1:0];
                err_set     <= !arg_ok;
              end
              OP_START: begin
                if (arg_ok) begin
                  start    <= 1'b1;
                  last_idx <= arg[IDX_W-1:0];
                end else begin
                  err_set <= 1'b1;
                end
              end
              OP_STOP: stop <= 1'b1;
              default: err_set <= 1'b1;
            endcase
          end
          P_PAY: begin
            cnt_reg <= cnt_reg + 4'd1;
            case (cnt_reg)
              4'd0: type_reg          <= cfg_data[1:0];
              4'd1: freq_reg[15:8]    <= cfg_data;
              4'd2: freq_reg[7:0]     <= cfg_data;
              4'd3: amp_reg[9:8]      <= cfg_data[1:0];
              4'd4: amp_reg[7:0]      <= cfg_data;
              4'd5: off_reg[9:8]      <= cfg_data[1:0];
              4'd6: off_reg[7:0]      <= cfg_data;
              4'd7: dur_hi_reg        <= cfg_data;
              default: ;
            endcase
            if (cnt_reg == 4'(PAY_BYTES - 1)) begin
              state_reg      <= P_HDR;
              wr_en          <= !discard_reg;
              wr_idx         <= idx_reg;
              wr_entry.wtype <= type_reg;
              wr_entry.freq  <= freq_reg;
              wr_entry.amp   <= amp_reg;
              wr_entry.off   <= off_reg;
              wr_entry.dur   <= {dur_hi_reg, cfg_data} & DUR_MASK;
            end
          end
          default: state_reg <= P_HDR;
        endcase
      end
    end
  end

endmodule

// File: rtl/awg_sequencer.sv
// awg_sequencer
//   Plays a table of waveform segments into the waveform generator. Segment
//   changes happen only on the generator's phase-wrap pulse so the output
//   waveform switches glitch-free. The table is loaded over the UART byte
//   stream through awg_cmd_parser.
// Ports
//   clk, rst_n            clock, async active-low reset
//   cfg_data, cfg_valid   received UART byte and strobe
//   phase_wrap            generator phase-accumulator wrap pulse
//   seg_type/freq/amp/offset  registered generator controls
//   seg_update            one-cycle pulse whenever seg_* change
//   seg_idx               index of the segment now playing
//   busy                  high while armed or running
//   err                   sticky protocol error, cleared by CLR
module awg_sequencer
  import awg_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int DUR_W   = 16,
  parameter int IDX_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  input  logic             phase_wrap,
  output logic [1:0]       seg_type,
  output logic [15:0]      seg_freq,
  output logic [9:0]       seg_amp,
  output logic [9:0]       seg_offset,
  output logic             seg_update,
  output logic [IDX_W-1:0] seg_idx,
  output logic             busy,
  output logic             err
);

  // Reset is asserted asynchronously but released only on a clock edge,
  // so no flop sees a deassertion near its sampling point.
  logic [1:0] rst_sync_reg;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_int_n = rst_sync_reg[1];

  // Command parser
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  seg_entry_t       wr_entry;
  logic             start;
  logic [IDX_W-1:0] last_idx;
  logic             stop;
  logic             clr;
  logic             err_set;

  awg_cmd_parser #(
    .NUM_SEG (NUM_SEG),
    .DUR_W   (DUR_W),
    .IDX_W   (IDX_W)
  ) u_parser (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_entry  (wr_entry),
    .start     (start),
    .last_idx  (last_idx),
    .stop      (stop),
    .clr       (clr),
    .err_set   (err_set)
  );

  // Segment table: one register per entry, cleared by reset
  seg_entry_t tbl_reg [NUM_SEG];

  generate
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_tbl
      always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)                              tbl_reg[gi] <= '0;
        else if (wr_en && (wr_idx == IDX_W'(gi)))    tbl_reg[gi] <= wr_entry;
      end
    end
  endgenerate

  // Sticky error
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   err <= 1'b0;
    else if (clr)     err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Player
  play_state_t      state_reg;
  logic [IDX_W-1:0] last_reg;
  logic [DUR_W-1:0] dur_cnt_reg;

  logic [IDX_W-1:0] load_idx;
  seg_entry_t       load_entry;
  logic [DUR_W-1:0] load_dur_raw;
  logic [DUR_W-1:0] load_dur;

  // Entry that the next load would pick up. From ARM it is always entry 0;
  // while running it is the successor of the current index within the loop.
  // A commit landing in the same cycle is not visible here yet, so the load
  // sees the previous contents.
  always_comb begin
    load_idx = '0;
    if (state_reg == S_RUN && seg_idx != last_reg) load_idx = seg_idx + IDX_W'(1);
    load_entry   = tbl_reg[load_idx];
    load_dur_raw = load_entry.dur[DUR_W-1:0];
    load_dur     = (load_dur_raw == '0) ? DUR_W'(1) : load_dur_raw;
  end

  assign busy = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg   <= S_IDLE;
      last_reg    <= '0;
      dur_cnt_reg <= '0;
      seg_type    <= '0;
      seg_freq    <= '0;
      seg_amp     <= '0;
      seg_offset  <= '0;
      seg_update  <= 1'b0;
      seg_idx     <= '0;
    end else begin
      seg_update <= 1'b0;
      // Commands take priority over a coincident wrap
      if (stop) begin
        state_reg  <= S_IDLE;
        seg_amp    <= '0;
        seg_offset <= '0;
        seg_update <= (state_reg == S_RUN);
      end else if (start) begin
        state_reg <= S_ARM;
        last_reg  <= last_idx;
      end else if (phase_wrap) begin
        case (state_reg)
          S_ARM, S_RUN: begin
            if (state_reg == S_RUN && dur_cnt_reg > DUR_W'(1)) begin
              dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
            end else begin
              state_reg   <= S_RUN;
              seg_idx     <= load_idx;
              seg_type    <= load_entry.wtype;
              seg_freq    <= load_entry.freq;
              seg_amp     <= load_entry.amp;
              seg_offset  <= load_entry.off;
              dur_cnt_reg <= load_dur;
              seg_update  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_awg_sequencer.sv
module tb_awg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg_data = 8'h00;
  logic        cfg_valid = 1'b0;
  logic        phase_wrap = 1'b0;
  logic [1:0]  seg_type;
  logic [15:0] seg_freq;
  logic [9:0]  seg_amp;
  logic [9:0]  seg_offset;
  logic        seg_update;
  logic [1:0]  seg_idx;
  logic        busy;
  logic        err;

  awg_sequencer #(.NUM_SEG(4), .DUR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .phase_wrap (phase_wrap),
    .seg_type   (seg_type),
    .seg_freq   (seg_freq),
    .seg_amp    (seg_amp),
    .seg_offset (seg_offset),
    .seg_update (seg_update),
    .seg_idx    (seg_idx),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Expected segment updates, in order
  typedef struct packed {
    logic [1:0]  t;
    logic [15:0] f;
    logic [9:0]  a;
    logic [9:0]  o;
    logic [1:0]  i;
  } upd_t;
  upd_t upd_q[$];

  // Expected status values, checked at the next falling edge
  localparam logic [2:0] K_ALL = 3'd0, K_ERR = 3'd1, K_BUSY = 3'd2, K_AMP = 3'd3, K_END = 3'd4;
  typedef struct packed {
    logic [2:0]  kind;
    logic [63:0] val;
  } chk_t;
  chk_t chk_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  upd_t  mon_got;
  upd_t  mon_exp;
  chk_t  mon_chk;
  logic [63:0] mon_val;
  string mon_name;

  // Monitor: pops and compares against whatever the DUT presents
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      mon_chk = chk_q.pop_front();
      case (mon_chk.kind)
        K_ALL:  begin mon_name = "reset_outputs"; mon_val = 64'({seg_type, seg_freq, seg_amp, seg_offset, seg_update, seg_idx, busy, err}); end
        K_ERR:  begin mon_name = "err";           mon_val = 64'(err); end
        K_BUSY: begin mon_name = "busy";          mon_val = 64'(busy); end
        K_AMP:  begin mon_name = "seg_amp_hold";  mon_val = 64'(seg_amp); end
        default: begin mon_name = "pending_updates"; mon_val = 64'(upd_q.size()); end
      endcase
      n_cmp++;
      if (mon_val !== mon_chk.val) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", mon_name, mon_val, mon_chk.val, $time);
      end else begin
        $display("ok   %s = %0h (t=%0t)", mon_name, mon_val, $time);
      end
    end
    if (seg_update === 1'b1) begin
      mon_got = {seg_type, seg_freq, seg_amp, seg_offset, seg_idx};
      n_cmp++;
      if (upd_q.size() == 0) begin
        n_bad++;
        $display("FAIL seg_update_unexpected: got type=%0h freq=%0h amp=%0h off=%0h idx=%0h expected no update (t=%0t)",
                 seg_type, seg_freq, seg_amp, seg_offset, seg_idx, $time);
      end else begin
        mon_exp = upd_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_bad++;
          $display("FAIL seg_update: got type=%0h freq=%0h amp=%0h off=%0h idx=%0h expected type=%0h freq=%0h amp=%0h off=%0h idx=%0h (t=%0t)",
                   seg_type, seg_freq, seg_amp, seg_offset, seg_idx,
                   mon_exp.t, mon_exp.f, mon_exp.a, mon_exp.o, mon_exp.i, $time);
        end else begin
          $display("ok   seg_update type=%0h freq=%0h amp=%0h off=%0h idx=%0h (t=%0t)",
                   seg_type, seg_freq, seg_amp, seg_offset, seg_idx, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    cfg_data  = b;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] b);
    send(b);
    idle(3);
  endtask

  task automatic write_seg(input logic [3:0] idx, input logic [1:0] t, input logic [15:0] f,
                           input logic [9:0] a, input logic [9:0] o, input logic [15:0] d);
    send({4'h1, idx});
    send({6'b0, t});
    send(f[15:8]);
    send(f[7:0]);
    send({6'b0, a[9:8]});
    send(a[7:0]);
    send({6'b0, o[9:8]});
    send(o[7:0]);
    send(d[15:8]);
    send(d[7:0]);
    idle(3);
  endtask

  task automatic wrap();
    @(posedge clk); #1;
    phase_wrap = 1'b1;
    @(posedge clk); #1;
    phase_wrap = 1'b0;
    idle(8);
  endtask

  // STOP strobe reaches the player in the same cycle as a phase wrap
  task automatic stop_with_wrap();
    @(posedge clk); #1;
    cfg_data  = 8'h30;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid  = 1'b0;
    phase_wrap = 1'b1;
    @(posedge clk); #1;
    phase_wrap = 1'b0;
    idle(3);
  endtask

  task automatic exp_upd(input logic [1:0] t, input logic [15:0] f, input logic [9:0] a,
                         input logic [9:0] o, input logic [1:0] i);
    upd_q.push_back({t, f, a, o, i});
  endtask

  task automatic chk(input logic [2:0] kind, input logic [63:0] val);
    chk_q.push_back({kind, val});
    idle(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset state, reset mid-WRITE, then a clean WRITE of entry 0
    rst_n = 1'b0;
    idle(3);
    chk(K_ALL, 64'd0);
    rst_n = 1'b1;
    idle(4);
    send(8'h10); send(8'h03); send(8'hAB); send(8'hCD);
    rst_n = 1'b0;
    #1;
    chk(K_ALL, 64'd0);
    rst_n = 1'b1;
    idle(4);
    write_seg(4'd0, 2'd3, 16'hABCD, 10'h155, 10'h2AA, 16'd1);
    cmd(8'h20);
    chk(K_BUSY, 64'd1);
    exp_upd(2'd3, 16'hABCD, 10'h155, 10'h2AA, 2'd0);
    wrap();
    exp_upd(2'd3, 16'hABCD, 10'h000, 10'h000, 2'd0);
    cmd(8'h30);
    chk(K_BUSY, 64'd0);

    // 2. two-segment loop, seg0 lasts two periods
    write_seg(4'd0, 2'd1, 16'h1000, 10'h3FF, 10'h000, 16'd2);
    write_seg(4'd1, 2'd2, 16'h2000, 10'h100, 10'h080, 16'd1);
    cmd(8'h21);
    exp_upd(2'd1, 16'h1000, 10'h3FF, 10'h000, 2'd0);
    wrap();
    wrap();
    exp_upd(2'd2, 16'h2000, 10'h100, 10'h080, 2'd1);
    wrap();
    exp_upd(2'd1, 16'h1000, 10'h3FF, 10'h000, 2'd0);
    wrap();
    chk(K_AMP, 64'h3FF);
    wrap();
    exp_upd(2'd2, 16'h2000, 10'h100, 10'h080, 2'd1);
    wrap();
    exp_upd(2'd2, 16'h2000, 10'h000, 10'h000, 2'd1);
    cmd(8'h30);

    // 3. zero durations advance on every wrap
    write_seg(4'd0, 2'd1, 16'h1111, 10'h0AA, 10'h055, 16'd0);
    write_seg(4'd1, 2'd0, 16'h0555, 10'h011, 10'h022, 16'd0);
    cmd(8'h21);
    exp_upd(2'd1, 16'h1111, 10'h0AA, 10'h055, 2'd0);
    wrap();
    exp_upd(2'd0, 16'h0555, 10'h011, 10'h022, 2'd1);
    wrap();
    exp_upd(2'd1, 16'h1111, 10'h0AA, 10'h055, 2'd0);
    wrap();

    // 4. STOP coincident with wrap: no advance, amp/offset zeroed
    exp_upd(2'd1, 16'h1111, 10'h000, 10'h000, 2'd0);
    stop_with_wrap();
    chk(K_BUSY, 64'd0);
    wrap();

    // 5. protocol errors
    cmd(8'h70);
    chk(K_ERR, 64'd1);
    cmd(8'h00);
    chk(K_ERR, 64'd0);
    send(8'h19);
    send(8'h30); send(8'h13); send(8'h20); send(8'h10); send(8'h22);
    send(8'h11); send(8'h05); send(8'h31); send(8'h21);
    idle(3);
    chk(K_ERR, 64'd1);
    chk(K_BUSY, 64'd0);
    cmd(8'h00);
    cmd(8'h25);
    chk(K_ERR, 64'd1);
    chk(K_BUSY, 64'd0);
    cmd(8'h00);
    chk(K_ERR, 64'd0);
    cmd(8'h21);
    exp_upd(2'd1, 16'h1111, 10'h0AA, 10'h055, 2'd0);
    wrap();
    exp_upd(2'd0, 16'h0555, 10'h011, 10'h022, 2'd1);
    wrap();

    // 6. rewrite the playing entry: takes effect only when it reloads
    write_seg(4'd1, 2'd3, 16'h7777, 10'h1FF, 10'h100, 16'd1);
    chk(K_AMP, 64'h011);
    exp_upd(2'd1, 16'h1111, 10'h0AA, 10'h055, 2'd0);
    wrap();
    exp_upd(2'd3, 16'h7777, 10'h1FF, 10'h100, 2'd1);
    wrap();
    exp_upd(2'd3, 16'h7777, 10'h000, 10'h000, 2'd1);
    cmd(8'h30);
    chk(K_END, 64'd0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
